top_level: RTL and testbench

Standalone half-precision (IEEE binary16) to 16-bit two's-complement integer converter with its own byte-wide data memory. The bench loads the float into fixed memory bytes and pulses `start`. The block reads the float, converts it with round-to-nearest and saturation, writes the integer back to memory, and raises `halt`. It is the top of the conversion program and the only block the bench instantiates.

---
 rtl/top_level_pkg.sv | 80 ++++++++
 rtl/data_mem.sv | 31 +++
 rtl/top_level.sv | 121 ++++++++++++
 tb/tb_top_level.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// ---------------------------------------------------------------------------
// top_level_pkg
// Shared definitions for the binary16 -> int16 conversion program.
//   - state_t   : controller states
//   - addresses : where the float is read from and the integer written to
//   - flt2int() : combinational float-to-integer conversion
// Optional feature macro: FLT2INT_SIGN_EN
//   defined     -> negative floats give negative integers (saturating at INT_MIN)
//   not defined -> the sign bit is ignored and the magnitude is returned
// ---------------------------------------------------------------------------
package top_level_pkg;

    typedef enum logic [2:0] {
        HALT,
        ARM,
        RD_HI,
        RD_LO,
        CALC,
        WR_HI,
        WR_LO
    } state_t;

    localparam logic [7:0]  FLT_ADDR = 8'd4;
    localparam logic [7:0]  INT_ADDR = 8'd6;
    localparam int          BIAS     = 15;
    localparam int          FRAC_W   = 10;
    localparam logic [15:0] INT_MAX  = 16'h7FFF;
    localparam logic [15:0] INT_MIN  = 16'h8000;

    // Exponent at which the 11-bit significand is already an integer
    // (value = M * 2^(E - EXP_UNITY)).
    localparam logic [4:0]  EXP_UNITY = 5'(BIAS + FRAC_W);
    // First exponent whose smallest value (1024 * 2^5) no longer fits in 15 bits.
    localparam logic [4:0]  EXP_SAT   = 5'd30;

    // Converts a binary16 pattern to a 16-bit integer, rounding half away
    // from zero and saturating large magnitudes (including inf/NaN).
    function automatic logic [15:0] flt2int(input logic [15:0] f);
        logic [4:0]  e;
        logic [10:0] m;
        logic [4:0]  s;
        logic [26:0] wide;
        logic [10:0] half;
        logic [15:0] mag;
        e    = f[14:10];
        m    = {(e != 5'd0), f[9:0]};
        s    = '0;
        wide = '0;
        half = '0;
        mag  = '0;
        if (e >= EXP_SAT) begin
            mag = INT_MAX;
        end else if (e >= EXP_UNITY) begin
            wide = {16'b0, m} << (e - EXP_UNITY);
            mag  = wide[15:0];
        end else begin
            s = EXP_UNITY - e;
            if (s > 5'd11) begin
                mag = '0;
            end else begin
                // Shift one place short so the lsb left over is the
                // first discarded bit, which is the rounding increment.
                half = m >> (s - 5'd1);
                mag  = {5'b0, half >> 1} + {15'b0, half[0]};
            end
        end
`ifdef FLT2INT_SIGN_EN
        if (f[15]) begin
            if (e >= EXP_SAT) begin
                return INT_MIN;
            end
            return ~mag + 16'd1;
        end
        return mag;
`else
        return mag;
`endif
    endfunction

endpackage

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// 256 x 8 single-port data memory: combinational read, synchronous write.
// Contents are never reset.
// Ports:
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_addr  : byte address (read and write)
//   i_wdata : write data
//   o_rdata : read data at i_addr
// ---------------------------------------------------------------------------
module data_mem (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);

    logic [7:0] core [0:255];

    // Write port; the array is left unreset so a reset never disturbs data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            core[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = core[i_addr];

endmodule

// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level
// Reads a binary16 float from data memory bytes 4/5, converts it to a
// 16-bit integer (round half away from zero, saturating) and writes the
// result to bytes 6/7, then raises halt.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous, active-high
//   start : request; memory is loaded while it is high, the run begins
//           when it drops
//   halt  : high while idle / done
// Optional feature macro: FLT2INT_SIGN_EN (signed conversion, see package)
// ---------------------------------------------------------------------------
module top_level
    import top_level_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic start,
    output logic halt
);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_floatHi;
    logic [7:0]  r_floatLo;
    logic [15:0] r_int;
    logic        r_halt;

    logic        w_memWe;
    logic [7:0]  w_memAddr;
    logic [7:0]  w_memWdata;
    logic [7:0]  w_memRdata;

    data_mem data_mem (
        .i_clk   (CLK),
        .i_we    (w_memWe),
        .i_addr  (w_memAddr),
        .i_wdata (w_memWdata),
        .o_rdata (w_memRdata)
    );

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= HALT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sequencing and memory port control. Each memory access gets its own
    // state because the memory has a single port.
    always_comb begin
        w_nextState = r_state;
        w_memWe     = 1'b0;
        w_memAddr   = FLT_ADDR;
        w_memWdata  = 8'h00;
        case (r_state)
            HALT: begin
                if (start) begin
                    w_nextState = ARM;
                end
            end
            ARM: begin
                if (!start) begin
                    w_nextState = RD_HI;
                end
            end
            RD_HI: begin
                w_memAddr   = FLT_ADDR;
                w_nextState = RD_LO;
            end
            RD_LO: begin
                w_memAddr   = FLT_ADDR + 8'd1;
                w_nextState = CALC;
            end
            CALC: begin
                w_nextState = WR_HI;
            end
            WR_HI: begin
                w_memWe     = 1'b1;
                w_memAddr   = INT_ADDR;
                w_memWdata  = r_int[15:8];
                w_nextState = WR_LO;
            end
            WR_LO: begin
                w_memWe     = 1'b1;
                w_memAddr   = INT_ADDR + 8'd1;
                w_memWdata  = r_int[7:0];
                w_nextState = HALT;
            end
            default: begin
                w_nextState = HALT;
            end
        endcase
    end

    // Datapath registers. halt is registered and only re-asserts one cycle
    // after the FSM is back in HALT, so the flag trails the last write by a
    // full clock and drops on the same edge that accepts a new request.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_floatHi <= 8'h00;
            r_floatLo <= 8'h00;
            r_int     <= 16'h0000;
            r_halt    <= 1'b1;
        end else begin
            r_halt <= (r_state == HALT) && !start;
            case (r_state)
                RD_HI:   r_floatHi <= w_memRdata;
                RD_LO:   r_floatLo <= w_memRdata;
                CALC:    r_int     <= flt2int({r_floatHi, r_floatLo});
                default: ;
            endcase
        end
    end

    assign halt = r_halt;

endmodule

// File: tb/tb_top_level.sv
// ---------------------------------------------------------------------------
// tb_top_level
// Scoreboard bench for top_level: each request pushes its hand-computed
// result into a queue, and a monitor pops and compares the memory result
// whenever halt rises.
// ---------------------------------------------------------------------------
module tb_top_level;

    typedef struct {
        logic [15:0] flt;
        logic [15:0] expInt;
    } sbItem_t;

    logic CLK;
    logic Reset;
    logic start;
    logic halt;

    int checks;
    int errors;

    sbItem_t sbQueue[$];
    logic    prevHalt;
    logic    expectAbort;

    logic [15:0] vecFlt [0:18];
    logic [15:0] vecInt [0:18];

    top_level dut (
        .CLK   (CLK),
        .Reset (Reset),
        .start (start),
        .halt  (halt)
    );

    // 100 MHz style clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Shared comparison helper.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one conversion: loads the float while start is high, checks halt
    // drops, then counts edges until halt returns.
    task automatic applyStimulus(input logic [15:0] flt, input logic [15:0] expInt);
        sbItem_t item;
        int      edges;
        logic    done;
        item.flt    = flt;
        item.expInt = expInt;
        @(negedge CLK);
        dut.data_mem.core[4] = flt[15:8];
        dut.data_mem.core[5] = flt[7:0];
        sbQueue.push_back(item);
        start = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("halt falls", {15'b0, halt}, 16'h0000);
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 50) begin
            @(posedge CLK);
            edges++;
            #1;
            if (halt) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL halt timeout: flt %h, halt still %b after %0d edges", flt, halt, edges);
            void'(sbQueue.pop_back());
        end else begin
            checkOutput("halt rise latency", 16'(edges), 16'd6);
        end
    endtask

    // Monitor: compare memory result each time halt rises.
    initial begin
        sbItem_t item;
        forever begin
            @(negedge CLK);
            if (halt && !prevHalt) begin
                if (expectAbort) begin
                    expectAbort = 1'b0;
                end else if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected halt: no request outstanding, result %h",
                             {dut.data_mem.core[6], dut.data_mem.core[7]});
                end else begin
                    item = sbQueue.pop_front();
                    checkOutput($sformatf("result of %h", item.flt),
                                {dut.data_mem.core[6], dut.data_mem.core[7]}, item.expInt);
                end
            end
            prevHalt = halt;
        end
    end

    // Main sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        prevHalt    = 1'b1;
        expectAbort = 1'b0;
        Reset       = 1'b1;
        start       = 1'b0;

        vecFlt[0]  = 16'h0000; vecInt[0]  = 16'd0;
        vecFlt[1]  = 16'h3C00; vecInt[1]  = 16'd1;
        vecFlt[2]  = 16'h3E00; vecInt[2]  = 16'd2;
        vecFlt[3]  = 16'h3D00; vecInt[3]  = 16'd1;
        vecFlt[4]  = 16'h3F00; vecInt[4]  = 16'd2;
        vecFlt[5]  = 16'h4140; vecInt[5]  = 16'd3;
        vecFlt[6]  = 16'h4380; vecInt[6]  = 16'd4;
        vecFlt[7]  = 16'h4040; vecInt[7]  = 16'd2;
        vecFlt[8]  = 16'h4B00; vecInt[8]  = 16'd14;
        vecFlt[9]  = 16'h6300; vecInt[9]  = 16'd896;
        vecFlt[10] = 16'h6700; vecInt[10] = 16'd1792;
        vecFlt[11] = 16'h7780; vecInt[11] = 16'd30720;
        vecFlt[12] = 16'h7B80; vecInt[12] = 16'h7FFF;
        vecFlt[13] = 16'h7C00; vecInt[13] = 16'h7FFF;
`ifdef FLT2INT_SIGN_EN
        vecFlt[14] = 16'hBC00; vecInt[14] = 16'hFFFF;
`else
        vecFlt[14] = 16'hBC00; vecInt[14] = 16'd1;
`endif
        vecFlt[15] = 16'h3800; vecInt[15] = 16'd1;
        vecFlt[16] = 16'h3400; vecInt[16] = 16'd0;
        vecFlt[17] = 16'h77FF; vecInt[17] = 16'd32752;
        vecFlt[18] = 16'h4100; vecInt[18] = 16'd3;

        // Reset state; result bytes preloaded to show reset leaves memory alone.
        dut.data_mem.core[6] = 8'hA5;
        dut.data_mem.core[7] = 8'h5A;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("halt during reset", {15'b0, halt}, 16'h0001);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("halt after reset", {15'b0, halt}, 16'h0001);
        checkOutput("memory untouched by reset",
                    {dut.data_mem.core[6], dut.data_mem.core[7]}, 16'hA55A);

        $display("[TB] running %0d back-to-back conversions", 19);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecFlt[i], vecInt[i]);
        end

        // Abort a run while it is in CALC, then confirm recovery.
        @(negedge CLK);
        dut.data_mem.core[4] = 8'h3C;
        dut.data_mem.core[5] = 8'h00;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        expectAbort = 1'b1;
        Reset = 1'b1;
        #1;
        checkOutput("halt on mid-run reset", {15'b0, halt}, 16'h0001);
        repeat (2) @(negedge CLK);
        #1;
        Reset = 1'b0;
        applyStimulus(16'h4B00, 16'd14);

        repeat (4) @(negedge CLK);
        checkOutput("scoreboard drained", 16'(sbQueue.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
